// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search engine.
package sar_pkg;

   typedef enum logic [1:0] {IDLE, TRIAL, FIN} sar_state_t;

   localparam int SAR_WIDTH = 32;

   // True when exactly one of the three comparator flags is set.
   function automatic logic flags_ok(input logic gt, input logic lt, input logic eq);
      return (gt ^ lt ^ eq) & ~(gt & lt & eq);
   endfunction

endpackage

// File: rtl/sar_search_32.sv
// SAR search engine: drives comparator operand A bit by bit (MSB first) and
// rebuilds the unknown B operand from the GT/LT/EQ flags, stopping early on EQ.
module sar_search_32
   import sar_pkg::*;
#(
   parameter int WIDTH      = SAR_WIDTH,
   parameter int SETTLE_CYC = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             gt,
   input  logic             lt,
   input  logic             eq,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             exact,
   output logic             err
);

   localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int SW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

   localparam logic [KW-1:0]    K_TOP       = KW'(WIDTH - 1);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC);
   localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
   localparam logic [WIDTH-1:0] MSB_MASK    = ONE << (WIDTH - 1);

   sar_state_t       state_reg;
   logic [KW-1:0]    k_reg;
   logic [SW-1:0]    settle_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] probe_reg;
   logic [WIDTH-1:0] result_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             exact_reg;
   logic             err_reg;

   logic [WIDTH-1:0] bit_mask;
   logic [WIDTH-1:0] next_mask;
   logic [WIDTH-1:0] acc_next;
   logic             sample_edge;

   assign bit_mask    = ONE << k_reg;
   assign next_mask   = bit_mask >> 1;
   assign acc_next    = lt ? (acc_reg | bit_mask) : acc_reg;
   assign sample_edge = (settle_reg == SETTLE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         k_reg      <= K_TOP;
         settle_reg <= '0;
         acc_reg    <= '0;
         probe_reg  <= '0;
         result_reg <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         exact_reg  <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg  <= TRIAL;
                  k_reg      <= K_TOP;
                  settle_reg <= '0;
                  acc_reg    <= '0;
                  probe_reg  <= MSB_MASK;
                  busy_reg   <= 1'b1;
                  exact_reg  <= 1'b0;
                  err_reg    <= 1'b0;
               end
            end
            TRIAL: begin
               if (!sample_edge) begin
                  settle_reg <= settle_reg + SW'(1);
               end else begin
                  settle_reg <= '0;
                  if (!flags_ok(gt, lt, eq)) begin
                     state_reg  <= FIN;
                     err_reg    <= 1'b1;
                     result_reg <= '0;
                     probe_reg  <= '0;
                     busy_reg   <= 1'b0;
                     done_reg   <= 1'b1;
                  end else if (eq) begin
                     // probe_reg already holds the matching value, so it keeps mirroring result.
                     state_reg  <= FIN;
                     exact_reg  <= 1'b1;
                     result_reg <= probe_reg;
                     busy_reg   <= 1'b0;
                     done_reg   <= 1'b1;
                  end else if (k_reg == '0) begin
                     state_reg  <= FIN;
                     result_reg <= acc_next;
                     probe_reg  <= acc_next;
                     busy_reg   <= 1'b0;
                     done_reg   <= 1'b1;
                  end else begin
                     k_reg     <= k_reg - KW'(1);
                     acc_reg   <= acc_next;
                     probe_reg <= acc_next | next_mask;
                  end
               end
            end
            FIN: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign probe  = probe_reg;
   assign busy   = busy_reg;
   assign done   = done_reg;
   assign result = result_reg;
   assign exact  = exact_reg;
   assign err    = err_reg;

endmodule

// File: tb/tb_sar_search_32.sv
// Bench for sar_search_32: one engine on a combinational comparator, one on a
// registered comparator with SETTLE_CYC=2, checked against an arithmetic reference.
module tb_sar_search_32;
   import sar_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst0, rst2, start0, start2, force_bad;
   logic [W-1:0] unk0, unk2;
   logic         gt0, lt0, eq0, gt2, lt2, eq2;
   logic [W-1:0] probe0, result0, probe2, result2;
   logic         busy0, done0, exact0, err0, busy2, done2, exact2, err2;

   int total = 0;
   int passed = 0;
   int done_cnt0 = 0;

   sar_search_32 #(.WIDTH(W), .SETTLE_CYC(0)) dut0 (
      .clk(clk), .rst(rst0), .start(start0), .gt(gt0), .lt(lt0), .eq(eq0),
      .probe(probe0), .busy(busy0), .done(done0), .result(result0),
      .exact(exact0), .err(err0)
   );

   sar_search_32 #(.WIDTH(W), .SETTLE_CYC(2)) dut2 (
      .clk(clk), .rst(rst2), .start(start2), .gt(gt2), .lt(lt2), .eq(eq2),
      .probe(probe2), .busy(busy2), .done(done2), .result(result2),
      .exact(exact2), .err(err2)
   );

   // Combinational comparator with a fault override; registered comparator for the slow engine.
   always_comb begin
      gt0 = probe0 > unk0;
      lt0 = probe0 < unk0;
      eq0 = probe0 == unk0;
      if (force_bad) begin
         gt0 = 1'b1;
         lt0 = 1'b1;
         eq0 = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      gt2 <= probe2 > unk2;
      lt2 <= probe2 < unk2;
      eq2 <= probe2 == unk2;
   end

   always @(posedge clk) if (done0) done_cnt0 <= done_cnt0 + 1;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
   endtask

   // Number of trials: one per bit down to the lowest set bit, or all bits for zero.
   function automatic int ref_trials(input logic [W-1:0] u);
      if (u == '0) return W;
      for (int i = 0; i < W; i++) if (u[i]) return W - i;
      return W;
   endfunction

   task automatic pulse_start(input int s);
      @(negedge clk);
      if (s == 0) start0 = 1'b1; else start2 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic run_search(input int s, input logic [W-1:0] u, input string tag);
      int cyc;
      int per;
      logic d;
      per = (s == 0) ? 1 : 3;
      if (s == 0) unk0 = u; else unk2 = u;
      pulse_start(s);
      cyc = 0;
      d = (s == 0) ? done0 : done2;
      while (!d && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
         d = (s == 0) ? done0 : done2;
      end
      chk({tag, " latency"}, W'(cyc), W'(ref_trials(u) * per));
      chk({tag, " result"}, (s == 0) ? result0 : result2, u);
      chk({tag, " exact"}, W'((s == 0) ? exact0 : exact2), W'(u != '0));
      chk({tag, " err"}, W'((s == 0) ? err0 : err2), W'(0));
      chk({tag, " busy"}, W'((s == 0) ? busy0 : busy2), W'(0));
      chk({tag, " probe"}, (s == 0) ? probe0 : probe2, u);
      $display("txn %s engine=%0d unknown=%h result=%h cycles=%0d", tag, s, u,
               (s == 0) ? result0 : result2, cyc);
      @(posedge clk);
      #1;
      chk({tag, " done pulse"}, W'((s == 0) ? done0 : done2), W'(0));
   endtask

   initial begin
      int cyc;
      int snap;
      logic [W-1:0] u;

      rst0 = 1'b1; rst2 = 1'b1; start0 = 1'b0; start2 = 1'b0; force_bad = 1'b0;
      unk0 = '0; unk2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", W'(busy0), W'(0));
      chk("reset done", W'(done0), W'(0));
      chk("reset probe", probe0, '0);
      chk("reset result", result0, '0);
      chk("reset exact", W'(exact0), W'(0));
      chk("reset err", W'(err0), W'(0));
      chk("reset busy2", W'(busy2), W'(0));
      chk("reset probe2", probe2, '0);
      rst0 = 1'b0; rst2 = 1'b0;
      $display("txn reset released");

      run_search(0, 32'h8000_0000, "msb");
      run_search(0, 32'h0000_0001, "lsb");
      run_search(0, 32'h0000_0000, "zero");

      // Slow comparator: probe held for three cycles per trial.
      unk2 = 32'h0000_0100;
      pulse_start(2);
      chk("hold c0", probe2, 32'h8000_0000);
      cyc = 0;
      while (!done2 && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1 || cyc == 2) chk("hold c12", probe2, 32'h8000_0000);
         if (cyc == 3) chk("hold c3", probe2, 32'h4000_0000);
      end
      chk("slow latency", W'(cyc), W'(72));
      chk("slow result", result2, 32'h0000_0100);
      chk("slow exact", W'(exact2), W'(1));
      $display("txn slow unknown=%h result=%h cycles=%0d", unk2, result2, cyc);

      // Flag fault on the 4th trial.
      unk0 = 32'hDEAD_BEEF;
      pulse_start(0);
      cyc = 0;
      while (!done0 && cyc < 400) begin
         if (cyc == 3) force_bad = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
         force_bad = 1'b0;
      end
      chk("fault latency", W'(cyc), W'(4));
      chk("fault err", W'(err0), W'(1));
      chk("fault result", result0, '0);
      chk("fault exact", W'(exact0), W'(0));
      $display("txn fault unknown=%h err=%0b cycles=%0d", unk0, err0, cyc);
      @(posedge clk);
      #1;

      // Reset during trial 10.
      snap = done_cnt0;
      unk0 = 32'h0000_0001;
      pulse_start(0);
      repeat (9) @(posedge clk);
      #1;
      rst0 = 1'b1;
      @(posedge clk);
      #1;
      rst0 = 1'b0;
      chk("abort busy", W'(busy0), W'(0));
      chk("abort probe", probe0, '0);
      chk("abort result", result0, '0);
      chk("abort done", W'(done0), W'(0));
      repeat (3) @(posedge clk);
      #1;
      chk("abort no done", W'(done_cnt0 - snap), W'(0));
      $display("txn abort done_count_delta=%0d", done_cnt0 - snap);
      run_search(0, 32'h1234_5678, "after abort");

      // START during TRIAL and during FIN must be ignored.
      snap = done_cnt0;
      unk0 = 32'h0000_0F00;
      pulse_start(0);
      cyc = 0;
      while (!done0 && cyc < 400) begin
         start0 = (cyc == 5);
         @(posedge clk);
         #1;
         cyc++;
      end
      start0 = 1'b0;
      chk("ign latency", W'(cyc), W'(24));
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      chk("ign fin busy", W'(busy0), W'(0));
      repeat (3) @(posedge clk);
      #1;
      chk("ign idle busy", W'(busy0), W'(0));
      chk("ign done count", W'(done_cnt0 - snap), W'(1));
      chk("ign result", result0, 32'h0000_0F00);
      $display("txn ignore result=%h dones=%0d", result0, done_cnt0 - snap);

      for (int i = 0; i < 12; i++) begin
         u = $urandom;
         u = u << $urandom_range(0, 31);
         run_search(0, u, "rand0");
      end
      for (int i = 0; i < 4; i++) begin
         u = $urandom;
         u = u << $urandom_range(0, 31);
         run_search(2, u, "rand2");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
